// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: FSM state encoding, interrupt drain depth and
// the saturating increment used by the optional performance counters.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        StRun   = 3'd0,
        StFlush = 3'd1,
        StDrain = 3'd2,
        StVec   = 3'd3,
        StHalt  = 3'd4
    } state_e;

    localparam logic [1:0] DrainDepth = 2'd2;
    localparam int unsigned PerfWidth = 16;

    function automatic logic [PerfWidth-1:0] sat_inc(input logic [PerfWidth-1:0] v);
        return (&v) ? v : v + PerfWidth'(1);
    endfunction

endpackage

// File: rtl/loaduse_det.sv
// Load-use hazard comparator: the ID instruction reads the register a load in EX
// is about to write.
module loaduse_det (
    input  logic       mem_read,
    input  logic [1:0] rd,
    input  logic [1:0] rs,
    input  logic [1:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    output logic       hazard
);

    assign hazard = mem_read && ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard, branch-flush, interrupt and halt controller.
// Define PIPE_CTRL_PERF_EN to add the StallCnt/FlushCnt performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MemRead_EX,
    input  logic [1:0] Rd_EX,
    input  logic [1:0] Rs_ID,
    input  logic [1:0] Rt_ID,
    input  logic       UseRs_ID,
    input  logic       UseRt_ID,
    input  logic       BranchTaken_EX,
    input  logic       Halt_ID,
    input  logic       IntReq,
    input  logic       MemBusy,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       Pipe_Freeze,
    output logic       IntVecSel,
    output logic       Int_Ack,
    output logic [2:0] State
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PerfWidth-1:0] StallCnt,
    output logic [PerfWidth-1:0] FlushCnt
`endif
);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       lu_q, lu_d;
    logic       lu_hit, lu_fire;

    loaduse_det u_loaduse_det (
        .mem_read (MemRead_EX),
        .rd       (Rd_EX),
        .rs       (Rs_ID),
        .rt       (Rt_ID),
        .use_rs   (UseRs_ID),
        .use_rt   (UseRt_ID),
        .hazard   (lu_hit)
    );

    // The EX slot right after a load-use stall always holds the inserted bubble,
    // so a second stall there would be spurious.
    assign lu_fire = rst_n && !MemBusy && (state_q == StRun) && !BranchTaken_EX && !IntReq
                     && lu_hit && !lu_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lu_d        = lu_q;
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        Pipe_Freeze = 1'b0;
        IntVecSel   = 1'b0;
        Int_Ack     = 1'b0;
        if (!rst_n) begin
            // Outputs stay at the RUN defaults; the register block does the reset.
        end else if (MemBusy) begin
            Pipe_Freeze = 1'b1;
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
        end else begin
            lu_d = lu_fire;
            unique case (state_q)
                StRun: begin
                    if (BranchTaken_EX) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        state_d     = StFlush;
                    end else if (IntReq) begin
                        PC_Write    = 1'b0;
                        IF_ID_Flush = 1'b1;
                        cnt_d       = DrainDepth;
                        state_d     = StDrain;
                    end else if (lu_fire) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end else if (Halt_ID) begin
                        state_d = StHalt;
                    end
                end
                StFlush: begin
                    IF_ID_Flush = 1'b1;
                    state_d     = StRun;
                end
                StDrain: begin
                    PC_Write    = 1'b0;
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    cnt_d       = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = StVec;
                    end
                end
                StVec: begin
                    IntVecSel = 1'b1;
                    Int_Ack   = 1'b1;
                    state_d   = StRun;
                end
                StHalt: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    if (IntReq) begin
                        cnt_d   = DrainDepth;
                        state_d = StDrain;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
            lu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lu_q    <= lu_d;
        end
    end

    assign State = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic stall_evt, flush_evt;

    assign stall_evt = rst_n && (MemBusy || lu_fire);
    assign flush_evt = rst_n && !MemBusy && (state_q == StRun) && BranchTaken_EX;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (stall_evt) StallCnt <= sat_inc(StallCnt);
            if (flush_evt) FlushCnt <= sat_inc(FlushCnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a queue-based behavioural model checked every
// cycle, plus hand-computed literal expectations for the key sequences.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       MemRead_EX;
    logic [1:0] Rd_EX, Rs_ID, Rt_ID;
    logic       UseRs_ID, UseRt_ID;
    logic       BranchTaken_EX, Halt_ID, IntReq, MemBusy;
    logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
    logic       Pipe_Freeze, IntVecSel, Int_Ack;
    logic [2:0] State;
    logic [9:0] outs;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Output vector: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze,
    //                 IntVecSel, Int_Ack, State[2:0]}
    localparam logic [9:0] ORun  = 10'b11_00000_000;
    localparam logic [9:0] OLu   = 10'b00_01000_000;
    localparam logic [9:0] OIrq  = 10'b01_10000_000;
    localparam logic [9:0] ODrn  = 10'b01_11000_010;
    localparam logic [9:0] OVec  = 10'b11_00011_011;
    localparam logic [9:0] OHalt = 10'b00_00000_100;

    pipe_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemRead_EX     (MemRead_EX),
        .Rd_EX          (Rd_EX),
        .Rs_ID          (Rs_ID),
        .Rt_ID          (Rt_ID),
        .UseRs_ID       (UseRs_ID),
        .UseRt_ID       (UseRt_ID),
        .BranchTaken_EX (BranchTaken_EX),
        .Halt_ID        (Halt_ID),
        .IntReq         (IntReq),
        .MemBusy        (MemBusy),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Flush    (ID_EX_Flush),
        .Pipe_Freeze    (Pipe_Freeze),
        .IntVecSel      (IntVecSel),
        .Int_Ack        (Int_Ack),
        .State          (State)
    );

    assign outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze,
                   IntVecSel, Int_Ack, State};

    always #5 clk = ~clk;

    // Model: a queue of the special cycles still owed (1 flush, 2 drain, 3 vector),
    // a halted flag, and whether the previous cycle was a load-use stall.
    int   plan[$];
    bit   halted   = 1'b0;
    bit   after_lu = 1'b0;
    bit   m_lu, m_stall;
    logic m_pw, m_iw, m_iff, m_ief, m_fz, m_vs, m_ack;
    int   m_st;
    logic [9:0] m_exp;

    always @(negedge clk) begin
        if (chk_en) begin
            m_pw = 1'b1; m_iw = 1'b1; m_iff = 1'b0; m_ief = 1'b0;
            m_fz = 1'b0; m_vs = 1'b0; m_ack = 1'b0;
            m_st = (plan.size() != 0) ? plan[0] : (halted ? 4 : 0);
            if (!rst_n) begin
                plan.delete();
                halted   = 1'b0;
                after_lu = 1'b0;
            end else if (MemBusy) begin
                m_fz = 1'b1; m_pw = 1'b0; m_iw = 1'b0;
            end else begin
                m_lu = MemRead_EX && ((UseRs_ID && Rs_ID == Rd_EX) ||
                                      (UseRt_ID && Rt_ID == Rd_EX));
                m_stall = 1'b0;
                if (plan.size() != 0) begin
                    case (plan[0])
                        1: m_iff = 1'b1;
                        2: begin m_pw = 1'b0; m_iff = 1'b1; m_ief = 1'b1; end
                        default: begin m_vs = 1'b1; m_ack = 1'b1; end
                    endcase
                    void'(plan.pop_front());
                end else if (halted) begin
                    m_pw = 1'b0; m_iw = 1'b0;
                    if (IntReq) begin
                        halted = 1'b0;
                        plan.push_back(2); plan.push_back(2); plan.push_back(3);
                    end
                end else if (BranchTaken_EX) begin
                    m_iff = 1'b1; m_ief = 1'b1;
                    plan.push_back(1);
                end else if (IntReq) begin
                    m_pw = 1'b0; m_iff = 1'b1;
                    plan.push_back(2); plan.push_back(2); plan.push_back(3);
                end else if (m_lu && !after_lu) begin
                    m_pw = 1'b0; m_iw = 1'b0; m_ief = 1'b1;
                    m_stall = 1'b1;
                end else if (Halt_ID) begin
                    halted = 1'b1;
                end
                after_lu = m_stall;
            end
            m_exp = {m_pw, m_iw, m_iff, m_ief, m_fz, m_vs, m_ack, 3'(m_st)};
            total++;
            if (outs !== m_exp) begin
                bad++;
                $display("FAIL model cycle %0d: got %b want %b", cyc, outs, m_exp);
            end
            cyc++;
        end
    end

    task automatic drv(input logic rst, input logic busy, input logic br, input logic irq,
                       input logic hlt, input logic mr, input logic urs, input logic urt,
                       input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
        rst_n = rst; MemBusy = busy; BranchTaken_EX = br; IntReq = irq; Halt_ID = hlt;
        MemRead_EX = mr; UseRs_ID = urs; UseRt_ID = urt; Rd_EX = rd; Rs_ID = rs; Rt_ID = rt;
    endtask

    task automatic idle();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [9:0] exp);
        @(negedge clk);
        total++;
        if (outs !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, outs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
        step();
        chk_en = 1'b1;
        lit("reset_defaults", ORun); step();
        idle(); lit("idle_run", ORun); step();

        // Load-use on Rs, Rt unused, Rt used, and no load
        drv(1, 0, 0, 0, 0, 1, 1, 0, 2'd2, 2'd2, 2'd0); lit("lu_rs_stall", OLu); step();
        idle(); lit("lu_rs_after", ORun); step();
        drv(1, 0, 0, 0, 0, 1, 1, 0, 2'd1, 2'd3, 2'd1); lit("lu_rt_unused", ORun); step();
        drv(1, 0, 0, 0, 0, 1, 0, 1, 2'd3, 2'd0, 2'd3); lit("lu_rt_stall", OLu); step();
        drv(1, 0, 0, 0, 0, 0, 1, 1, 2'd3, 2'd3, 2'd3); lit("no_load_no_stall", ORun); step();

        // Branch, held into FLUSH where it must be ignored
        drv(1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); lit("br_cycle0", 10'b11_11000_000);
        step();
        lit("br_cycle1", 10'b11_10000_001); step();
        idle(); lit("br_cycle2", ORun); step();

        // Interrupt from RUN
        drv(1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); lit("irq_enter", OIrq); step();
        lit("irq_drain1", ODrn); step();
        idle(); lit("irq_drain2", ODrn); step();
        lit("irq_vec", OVec); step();
        lit("irq_done", ORun); step();

        // Halt, five frozen cycles, then interrupt
        drv(1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0); lit("halt_enter", ORun); step();
        idle();
        for (int i = 0; i < 4; i++) begin
            lit("halt_hold", OHalt); step();
        end
        drv(1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); lit("halt_hold5", OHalt); step();
        idle(); lit("halt_drain1", ODrn); step();
        lit("halt_drain2", ODrn); step();
        lit("halt_vec", OVec); step();
        lit("halt_done", ORun); step();

        // MemBusy for three cycles in the middle of DRAIN
        drv(1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); step();
        idle(); lit("busy_pre", ODrn); step();
        drv(1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            lit("busy_hold", 10'b00_00100_010); step();
        end
        idle(); lit("busy_resume", ODrn); step();
        lit("busy_vec", OVec); step();
        lit("busy_done", ORun); step();

        // Reset during DRAIN and during VEC
        drv(1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); step();
        idle(); lit("rst_pre", ODrn); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); lit("rst_mid_drain", 10'b11_00000_010);
        step();
        idle(); lit("rst_after", ORun); step();
        lit("rst_no_ack", ORun); step();
        drv(1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); step();
        idle(); step(); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); lit("rst_in_vec", 10'b11_00000_011);
        step();
        idle(); lit("rst_vec_after", ORun); step();

        // Priority: busy > branch > irq > load-use > halt
        drv(1, 1, 1, 1, 1, 1, 1, 0, 2'd2, 2'd2, 2'd0); lit("prio_busy", 10'b00_00100_000);
        step();
        drv(1, 0, 1, 1, 1, 1, 1, 0, 2'd2, 2'd2, 2'd0); step();
        drv(1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); step();
        drv(1, 0, 0, 1, 1, 1, 1, 0, 2'd2, 2'd2, 2'd0); lit("prio_irq", OIrq); step();
        idle(); step(); step(); step(); step();
        drv(1, 0, 0, 0, 1, 1, 0, 1, 2'd1, 2'd0, 2'd1); lit("prio_lu", OLu); step();
        drv(1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0); step();
        drv(1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); lit("halt_ignores_br", OHalt); step();
        drv(1, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); lit("halt_busy", 10'b00_00100_100);
        step();
        drv(1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0); step();
        idle(); step(); step(); step(); step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
